// File: rtl/ucus_boru_hatti.sv
// rtl/ucus_boru_hatti.sv - four-stage passenger boarding pipeline with flight departure control
// Stages: S1 ID check, S2 baggage fee, S3 payment, S4 seat assignment and departure.
module ucus_boru_hatti #(
  parameter int BIT         = 6,
  parameter int KAPASITE    = 4,
  parameter int SERBEST_KG  = 20,
  parameter int BIRIM_UCRET = 2,
  parameter int OTO_KALKIS  = 0
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           giris_gecerli,
  input  logic [BIT-1:0] kimlik_no,
  input  logic           uyruk,
  input  logic [5:0]     agirlik,
  input  logic [8:0]     bakiye,
  input  logic           kalkis_iste,
  output logic           cikis_gecerli,
  output logic           binis,
  output logic [1:0]     hata_kodu,
  output logic [8:0]     k_bakiye,
  output logic [7:0]     yolcu_sayisi,
  output logic           kalkis,
  output logic [7:0]     ucus_yolcu,
  output logic [15:0]    toplam_gelir
);

  localparam logic [7:0]  KAP       = 8'(KAPASITE);
  localparam logic [39:0] SERBEST_W = 40'(SERBEST_KG);
  localparam logic [39:0] BIRIM_W   = 40'(BIRIM_UCRET);

  // S1 kimlik
  logic       s1_v_q, s1_gecerli_q, s1_uyruk_q;
  logic [5:0] s1_agirlik_q;
  logic [8:0] s1_bakiye_q;
  logic       gecerli_d;

  assign gecerli_d = (kimlik_no != '0) && (kimlik_no != '1);

  always_ff @(posedge saat) begin
    if (reset) begin
      s1_v_q       <= 1'b0;
      s1_gecerli_q <= 1'b0;
      s1_uyruk_q   <= 1'b0;
      s1_agirlik_q <= '0;
      s1_bakiye_q  <= '0;
    end else begin
      s1_v_q       <= giris_gecerli;
      s1_gecerli_q <= gecerli_d;
      s1_uyruk_q   <= uyruk;
      s1_agirlik_q <= agirlik;
      s1_bakiye_q  <= bakiye;
    end
  end

  // S2 bavul: wide arithmetic so large parameters saturate instead of wrapping
  logic       s2_v_q, s2_gecerli_q;
  logic [7:0] s2_ucret_q;
  logic [8:0] s2_bakiye_q;
  logic [39:0] agirlik_w, ucret_ham;
  logic [7:0] ucret_d;

  always_comb begin
    agirlik_w = {34'd0, s1_agirlik_q};
    ucret_ham = 40'd0;
    if (agirlik_w > SERBEST_W) ucret_ham = (agirlik_w - SERBEST_W) * BIRIM_W;
    if (s1_uyruk_q) ucret_ham = ucret_ham << 1;
    ucret_d = (ucret_ham > 40'd255) ? 8'd255 : ucret_ham[7:0];
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      s2_v_q       <= 1'b0;
      s2_gecerli_q <= 1'b0;
      s2_ucret_q   <= '0;
      s2_bakiye_q  <= '0;
    end else begin
      s2_v_q       <= s1_v_q;
      s2_gecerli_q <= s1_gecerli_q;
      s2_ucret_q   <= ucret_d;
      s2_bakiye_q  <= s1_bakiye_q;
    end
  end

  // S3 odeme
  logic       s3_v_q, s3_gecerli_q, s3_onay_q;
  logic [7:0] s3_ucret_q;
  logic [8:0] s3_bakiye_q, s3_k_bakiye_q;
  logic       onay_d;
  logic [8:0] k_bakiye_d;

  assign onay_d     = s2_gecerli_q && (s2_bakiye_q >= {1'b0, s2_ucret_q});
  assign k_bakiye_d = onay_d ? (s2_bakiye_q - {1'b0, s2_ucret_q}) : s2_bakiye_q;

  always_ff @(posedge saat) begin
    if (reset) begin
      s3_v_q        <= 1'b0;
      s3_gecerli_q  <= 1'b0;
      s3_onay_q     <= 1'b0;
      s3_ucret_q    <= '0;
      s3_bakiye_q   <= '0;
      s3_k_bakiye_q <= '0;
    end else begin
      s3_v_q        <= s2_v_q;
      s3_gecerli_q  <= s2_gecerli_q;
      s3_onay_q     <= onay_d;
      s3_ucret_q    <= s2_ucret_q;
      s3_bakiye_q   <= s2_bakiye_q;
      s3_k_bakiye_q <= k_bakiye_d;
    end
  end

  // S4 ucak
  logic        cikis_q, binis_q, kalkis_q;
  logic [1:0]  hata_q;
  logic [8:0]  k_bakiye_q;
  logic [7:0]  yolcu_q, ucus_q;
  logic [15:0] gelir_q;
  logic        dolu, binis_d, kalkis_d;
  logic [7:0]  etkin;
  logic [1:0]  hata_d;
  logic [16:0] gelir_top;
  logic [15:0] gelir_d;

  assign dolu      = (yolcu_q >= KAP);
  assign binis_d   = s3_v_q && s3_onay_q && !dolu;
  // A same-cycle boarding belongs to the flight that may be leaving now
  assign etkin     = yolcu_q + {7'd0, binis_d};
  assign kalkis_d  = (kalkis_iste && (etkin != 8'd0)) ||
                     ((OTO_KALKIS != 0) && (etkin == KAP));
  assign gelir_top = {1'b0, gelir_q} + {9'd0, s3_ucret_q};
  assign gelir_d   = gelir_top[16] ? 16'hFFFF : gelir_top[15:0];

  always_comb begin
    hata_d = 2'd0;
    if (!s3_gecerli_q)   hata_d = 2'd1;
    else if (!s3_onay_q) hata_d = 2'd2;
    else if (dolu)       hata_d = 2'd3;
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      cikis_q    <= 1'b0;
      binis_q    <= 1'b0;
      hata_q     <= '0;
      k_bakiye_q <= '0;
      yolcu_q    <= '0;
      kalkis_q   <= 1'b0;
      ucus_q     <= '0;
      gelir_q    <= '0;
    end else begin
      cikis_q  <= s3_v_q;
      binis_q  <= binis_d;
      kalkis_q <= kalkis_d;
      if (s3_v_q) begin
        hata_q     <= hata_d;
        k_bakiye_q <= binis_d ? s3_k_bakiye_q : s3_bakiye_q;
      end
      if (binis_d) gelir_q <= gelir_d;
      if (kalkis_d) begin
        ucus_q  <= etkin;
        yolcu_q <= 8'd0;
      end else begin
        yolcu_q <= etkin;
      end
    end
  end

  assign cikis_gecerli = cikis_q;
  assign binis         = binis_q;
  assign hata_kodu     = hata_q;
  assign k_bakiye      = k_bakiye_q;
  assign yolcu_sayisi  = yolcu_q;
  assign kalkis        = kalkis_q;
  assign ucus_yolcu    = ucus_q;
  assign toplam_gelir  = gelir_q;

endmodule

// File: doc/ucus_boru_hatti.md
UCUS_BORU_HATTI -- requirements
Module: ucus_boru_hatti

Interface
REQ-001 The block SHALL have parameter BIT, default 6, passenger ID width.
REQ-002 The block SHALL have parameter KAPASITE, default 4, number of seats per flight, with a legal range of 1..255.
REQ-003 The block SHALL have parameter SERBEST_KG, default 20, free baggage allowance in kg.
REQ-004 The block SHALL have parameter BIRIM_UCRET, default 2, fee per kg above the allowance.
REQ-005 The block SHALL have parameter OTO_KALKIS, default 0; when it is 1, the plane departs automatically when full.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port saat, input, 1 bit, the clock; all logic is on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have port giris_gecerli, input, 1 bit, marking that the passenger inputs are valid this cycle.
REQ-010 The block SHALL have port kimlik_no, input, BIT bits, passenger ID.
REQ-011 The block SHALL have port uyruk, input, 1 bit, nationality: 0 is domestic and 1 is foreign.
REQ-012 The block SHALL have port agirlik, input, 6 bits, baggage weight in kg.
REQ-013 The block SHALL have port bakiye, input, 9 bits, passenger balance.
REQ-014 The block SHALL have port kalkis_iste, input, 1 bit, a departure request from the tower.
REQ-015 The block SHALL have port cikis_gecerli, output, 1 bit, marking that the per-passenger result is valid.
REQ-016 The block SHALL have port binis, output, 1 bit, set when the passenger is boarded.
REQ-017 The block SHALL have port hata_kodu, output, 2 bits, the rejection reason.
REQ-018 The block SHALL have port k_bakiye, output, 9 bits, the remaining balance.
REQ-019 The block SHALL have port yolcu_sayisi, output, 8 bits, the number of passengers aboard the current flight.
REQ-020 The block SHALL have port kalkis, output, 1 bit, a one-cycle departure pulse.
REQ-021 The block SHALL have port ucus_yolcu, output, 8 bits, the passenger count of the last departed flight.
REQ-022 The block SHALL have port toplam_gelir, output, 16 bits, accumulated baggage revenue.

Function
REQ-023 The block SHALL be a 4-stage pipeline (S1 kimlik, S2 bavul, S3 odeme, S4 ucak), each stage carrying a valid bit plus all data needed downstream; there is no stall and a new passenger can enter every cycle.
REQ-024 S1 SHALL capture its inputs on a rising edge when giris_gecerli=1, and the stage valid SHALL be 0 otherwise.
REQ-025 The S4 results SHALL appear on the outputs after the 4th rising edge, counting the sampling edge as the 1st.
REQ-026 S1 SHALL compute gecerli = (kimlik_no != 0) AND (kimlik_no != all-ones).
REQ-027 S2 SHALL compute ucret = (agirlik > SERBEST_KG) ? (agirlik - SERBEST_KG) * BIRIM_UCRET : 0, doubled when uyruk=1.
REQ-028 The ucret computation SHALL use full-width internal arithmetic, saturate to 255, and be held as an 8-bit value.
REQ-029 S3 SHALL set onay = gecerli AND (bakiye >= ucret); k_bakiye SHALL be bakiye - ucret when onay=1, and bakiye unchanged otherwise.
REQ-030 S4 SHALL board the passenger iff onay=1 AND yolcu_sayisi < KAPASITE.
REQ-031 hata_kodu SHALL be 0 when boarded, 1 for an invalid ID, 2 for insufficient balance, and 3 for a full plane, with priority 1 > 2 > 3.
REQ-032 On each boarding, yolcu_sayisi SHALL increment and toplam_gelir SHALL add ucret, saturating at 65535.
REQ-033 A rejected passenger SHALL be charged nothing, and k_bakiye SHALL equal the input bakiye.
REQ-034 A departure event SHALL occur when kalkis_iste=1 and the effective count is >0, or, with OTO_KALKIS=1, when the effective count equals KAPASITE.
REQ-035 The effective count SHALL be yolcu_sayisi plus the boarding in the same cycle.
REQ-036 On a departure edge, kalkis SHALL be 1 for exactly one cycle, ucus_yolcu SHALL take the effective count, and yolcu_sayisi SHALL clear to 0.
REQ-037 A passenger boarding in the same cycle as a departure SHALL be counted in the departing flight.
REQ-038 kalkis_iste with an effective count of 0 SHALL be ignored, with no pulse and no change to ucus_yolcu.
REQ-039 kalkis_iste SHALL be sampled directly (unpipelined) and SHALL be independent of cikis_gecerli.
REQ-040 When cikis_gecerli=0, binis SHALL be 0, while hata_kodu and k_bakiye SHALL hold their previous values.
REQ-041 With OTO_KALKIS=0, passengers arriving at a full plane SHALL be rejected with hata_kodu=3 until a departure occurs.

Reset
REQ-042 While reset=1 at a rising edge, all stage valid bits SHALL clear and in-flight passengers SHALL be dropped with no output.
REQ-043 Reset SHALL clear all outputs (cikis_gecerli, binis, hata_kodu, k_bakiye, yolcu_sayisi, kalkis, ucus_yolcu, toplam_gelir) to 0.
REQ-044 The first valid output after reset deasserts SHALL come only from a passenger sampled after the deassertion.
REQ-045 Reset SHALL take priority over giris_gecerli and kalkis_iste.

Verification
REQ-046 The bench SHALL cover, with default parameters: ID 5, uyruk 0, 25 kg, bakiye 100 sampled at edge 1 -> at edge 4 cikis_gecerli=1, binis=1, hata_kodu=0, k_bakiye=90, yolcu_sayisi=1, toplam_gelir=10.
REQ-047 The bench SHALL cover: ID 63 (all-ones) -> hata_kodu=1, binis=0, k_bakiye unchanged; ID 7, uyruk 1, 60 kg, bakiye 100 -> ucret 160, hata_kodu=2.
REQ-048 The bench SHALL cover: 5 valid passengers back-to-back on consecutive cycles -> 4 boarded, 5th hata_kodu=3, yolcu_sayisi=4; then kalkis_iste -> kalkis pulse, ucus_yolcu=4, yolcu_sayisi=0.
REQ-049 The bench SHALL cover: OTO_KALKIS=1 with 4 consecutive passengers -> kalkis on the 4th boarding edge, ucus_yolcu=4; also kalkis_iste coinciding with the 2nd boarding -> ucus_yolcu=2.
REQ-050 The bench SHALL cover: reset asserted for one edge while 3 passengers are in flight -> no cikis_gecerli afterwards, all outputs 0; kalkis_iste with an empty plane -> no kalkis.
REQ-051 The bench SHALL cover: ucret saturation (63 kg, uyruk 1, SERBEST_KG=0, BIRIM_UCRET=4) -> ucret 255, and toplam_gelir saturating at 65535.
